// File: rtl/sample_scheduler_if.sv
// sample_scheduler_if: run control, converter handshake and sample stream of sample_scheduler
interface sample_scheduler_if #(
  parameter int WORD_LENGTH = 16,
  parameter int CHANNELS = 4,
  parameter int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1
);
  logic enable_i;
  logic [CHANNELS-1:0] channel_mask_i;
  logic conv_start_o;
  logic [CH_W-1:0] conv_channel_o;
  logic conv_done_i;
  logic [WORD_LENGTH-1:0] conv_data_i;
  logic sample_valid_o;
  logic sample_ready_i;
  logic [WORD_LENGTH-1:0] sample_data_o;
  logic [CH_W-1:0] sample_channel_o;
  logic busy_o;
  logic overrun_o;
`ifdef SAMPLE_SCHEDULER_TIMEOUT_EN
  logic timeout_o;
`endif
  modport master (
    input enable_i, channel_mask_i, conv_done_i, conv_data_i, sample_ready_i,
    output conv_start_o, conv_channel_o, sample_valid_o, sample_data_o, sample_channel_o, busy_o, overrun_o
`ifdef SAMPLE_SCHEDULER_TIMEOUT_EN
    , timeout_o
`endif
  );
  modport slave (
    output enable_i, channel_mask_i, conv_done_i, conv_data_i, sample_ready_i,
    input conv_start_o, conv_channel_o, sample_valid_o, sample_data_o, sample_channel_o, busy_o, overrun_o
`ifdef SAMPLE_SCHEDULER_TIMEOUT_EN
    , timeout_o
`endif
  );
endinterface

// File: rtl/sample_scheduler.sv
// sample_scheduler: frame-rate prescaler walking a channel mask through a converter; SAMPLE_SCHEDULER_TIMEOUT_EN adds a conversion watchdog
module sample_scheduler #(
  parameter int WORD_LENGTH = 16,
  parameter int SYSTEM_FREQUENCY = 100000000,
  parameter int SAMPLING_FREQUENCY = 1000000,
  parameter int CHANNELS = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clock_i,
  input logic reset_i,
  sample_scheduler_if.master bus
);
  localparam int DIV = SYSTEM_FREQUENCY / SAMPLING_FREQUENCY;
  localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  if (DIV < 2 || longint'(DIV) > (64'd1 << WORD_LENGTH) || TIMEOUT_CYCLES < 1) begin : bad_config
    $error("sample_scheduler: invalid configuration");
  end
  typedef enum logic [1:0] {IDLE, START, WAIT, OUTPUT} state_t;
  state_t state, state_nxt;
  logic [WORD_LENGTH-1:0] count, data;
  logic [CHANNELS-1:0] pending;
  logic [CH_W-1:0] channel, sample_channel;
  logic tick, load, advance, expired, overrun;
  function automatic logic [CH_W-1:0] lowest(input logic [CHANNELS-1:0] m);
    lowest = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) if (m[i]) lowest = CH_W'(i);
  endfunction
  assign tick = bus.enable_i && count == WORD_LENGTH'(DIV - 1);
  assign load = state == IDLE && tick && |bus.channel_mask_i;
  assign advance = (state == OUTPUT && bus.sample_ready_i) || expired;
`ifdef SAMPLE_SCHEDULER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] watchdog;
  logic timeout;
  assign expired = state == WAIT && !bus.conv_done_i && watchdog == WD_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clock_i) begin
    watchdog <= reset_i || state != WAIT ? '0 : watchdog + 1'b1;
    timeout <= !reset_i && bus.enable_i && (timeout || expired);
  end
  assign bus.timeout_o = timeout;
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge clock_i) state <= reset_i ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = load ? START : IDLE;
      START: state_nxt = WAIT;
      WAIT: state_nxt = bus.conv_done_i ? OUTPUT : expired ? (|pending ? START : IDLE) : WAIT;
      OUTPUT: state_nxt = bus.sample_ready_i ? (|pending ? START : IDLE) : OUTPUT;
      default: state_nxt = IDLE;
    endcase
    if (!bus.enable_i) state_nxt = IDLE;
  end
  // pending holds the channels of this frame not yet started; clearing its lowest bit walks upward
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count <= '0;
      pending <= '0;
      channel <= '0;
      data <= '0;
      sample_channel <= '0;
      overrun <= 1'b0;
    end else begin
      count <= !bus.enable_i || tick ? '0 : count + 1'b1;
      overrun <= bus.enable_i && (overrun || (tick && state != IDLE));
      if (load) begin
        channel <= lowest(bus.channel_mask_i);
        pending <= bus.channel_mask_i & (bus.channel_mask_i - 1'b1);
      end else if (advance && |pending) begin
        channel <= lowest(pending);
        pending <= pending & (pending - 1'b1);
      end
      if (state == WAIT && bus.conv_done_i) begin
        data <= bus.conv_data_i;
        sample_channel <= channel;
      end
    end
  end
  assign bus.conv_start_o = state == START;
  assign bus.conv_channel_o = channel;
  assign bus.sample_valid_o = state == OUTPUT;
  assign bus.sample_data_o = data;
  assign bus.sample_channel_o = sample_channel;
  assign bus.busy_o = state != IDLE;
  assign bus.overrun_o = overrun;
endmodule

// File: tb/tb_sample_scheduler.sv
// tb_sample_scheduler: randomized scoreboard bench for sample_scheduler against a frame-level reference model
module tb_sample_scheduler;
  localparam int DIV = 100;
  localparam int CHN = 4;
  localparam int WL = 16;
  typedef struct {
    logic [1:0] ch;
    logic [WL-1:0] data;
  } samp_t;
  logic clk = 0, rst = 1;
  sample_scheduler_if #(.WORD_LENGTH(WL), .CHANNELS(CHN)) bus ();
  sample_scheduler dut (.clock_i(clk), .reset_i(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0, n_start = 0;
  int rmode = 0, lat_fix = 3, lat;
  bit spurious = 0;
  int ph = 0, phase = 0;
  logic [1:0] fq[$];
  samp_t sq[$];
  bit ov_m = 0, tk;
  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, wanted %0d at %0t", name, act, exp, $time);
    end
  endtask
  initial begin
    bus.conv_done_i = 0;
    bus.conv_data_i = '0;
    forever begin
      @(negedge clk);
      bus.conv_done_i = 0;
      if (bus.conv_start_o) begin
        lat = lat_fix != 0 ? lat_fix : int'($urandom_range(1, 6));
        repeat (lat) @(negedge clk);
        bus.conv_done_i = 1;
        bus.conv_data_i = WL'($urandom);
      end else if (spurious && $urandom_range(0, 3) == 0) begin
        bus.conv_done_i = 1;
        bus.conv_data_i = WL'($urandom);
      end
    end
  end
  initial begin
    bus.sample_ready_i = 1;
    forever begin
      @(negedge clk);
      bus.sample_ready_i = rmode == 0 ? 1'b1 : rmode == 2 ? 1'b0 : ($urandom_range(0, 9) < 7);
    end
  end
  // reference model: a frame is the ascending list of mask bits seen at a tick, one channel per start
  initial forever begin
    @(negedge clk);
    #3;
    if (rst) begin
      ph = 0; phase = 0; ov_m = 0;
      fq.delete();
      sq.delete();
    end else begin
      if (bus.conv_start_o) n_start++;
      chk("busy", bus.busy_o, phase != 0);
      chk("overrun", bus.overrun_o, ov_m);
      if (bus.conv_start_o || phase == 1) chk("conv_start", bus.conv_start_o, phase == 1);
      if (phase != 0 && fq.size() > 0) chk("conv_channel", bus.conv_channel_o, fq[0]);
      if (bus.sample_valid_o || phase == 3) chk("sample_valid", bus.sample_valid_o, phase == 3);
      tk = bus.enable_i && ph == DIV - 1;
      ph = !bus.enable_i || tk ? 0 : ph + 1;
      if (!bus.enable_i) begin
        phase = 0; ov_m = 0;
        fq.delete();
        sq.delete();
      end else begin
        if (tk && phase != 0) ov_m = 1;
        case (phase)
          0: if (tk && bus.channel_mask_i != 0) begin
            for (int c = 0; c < CHN; c++) if (bus.channel_mask_i[c]) fq.push_back(2'(c));
            phase = 1;
          end
          1: phase = 2;
          2: if (bus.conv_done_i) begin
            sq.push_back('{fq[0], bus.conv_data_i});
            phase = 3;
          end
          3: if (bus.sample_ready_i) begin
            void'(fq.pop_front());
            phase = fq.size() > 0 ? 1 : 0;
          end
          default: phase = 0;
        endcase
      end
    end
  end
  initial forever begin
    @(negedge clk);
    #4;
    if (!rst && bus.enable_i && bus.sample_valid_o) begin
      if (sq.size() == 0) chk("sample_expected", 1, 0);
      else begin
        chk("sample_data", bus.sample_data_o, sq[0].data);
        chk("sample_channel", bus.sample_channel_o, sq[0].ch);
        if (bus.sample_ready_i) void'(sq.pop_front());
      end
    end
  end
  initial begin
    int s0;
    bit found;
    logic [WL-1:0] held;
    bus.enable_i = 0;
    bus.channel_mask_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_conv_start", bus.conv_start_o, 0);
    chk("rst_conv_channel", bus.conv_channel_o, 0);
    chk("rst_valid", bus.sample_valid_o, 0);
    chk("rst_data", bus.sample_data_o, 0);
    chk("rst_channel", bus.sample_channel_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_overrun", bus.overrun_o, 0);
    rst = 0;
    bus.enable_i = 1;
    spurious = 1;
    s0 = n_start;
    repeat (300) @(negedge clk);
    spurious = 0;
    chk("mask0_starts", n_start - s0, 0);
    chk("mask0_busy", bus.busy_o, 0);
    chk("mask0_overrun", bus.overrun_o, 0);
    bus.channel_mask_i = 4'b0101;
    s0 = n_start;
    repeat (300) @(negedge clk);
    chk("m0101_starts_ge4", n_start - s0 >= 4, 1);
    chk("m0101_overrun", bus.overrun_o, 0);
    lat_fix = 0;
    rmode = 1;
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) bus.channel_mask_i = 4'($urandom);
      bus.enable_i = $urandom_range(0, 699) != 0;
    end
    bus.enable_i = 0;
    rmode = 2;
    lat_fix = 3;
    bus.channel_mask_i = 4'b1111;
    repeat (8) @(negedge clk);
    bus.enable_i = 1;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      found = bus.sample_valid_o && bus.sample_channel_o == 0;
    end
    chk("stall_found_ch0", found, 1);
    held = bus.sample_data_o;
    s0 = n_start;
    repeat (50) @(negedge clk);
    chk("stall_data", bus.sample_data_o, held);
    chk("stall_valid", bus.sample_valid_o, 1);
    chk("stall_starts", n_start - s0, 0);
    rmode = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus.conv_start_o && bus.conv_channel_o == 1;
    end
    chk("ch1_start_after_ready", found, 1);
    repeat (120) @(negedge clk);
    rmode = 2;
    repeat (250) @(negedge clk);
    chk("overrun_set", bus.overrun_o, 1);
    bus.enable_i = 0;
    @(negedge clk);
    chk("disable_overrun", bus.overrun_o, 0);
    chk("disable_busy", bus.busy_o, 0);
    chk("disable_valid", bus.sample_valid_o, 0);
    bus.enable_i = 1;
    rmode = 0;
    bus.channel_mask_i = 4'b0001;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      found = bus.conv_start_o;
    end
    chk("wait_start_before_reset", found, 1);
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rwait_conv_start", bus.conv_start_o, 0);
    chk("rwait_conv_channel", bus.conv_channel_o, 0);
    chk("rwait_valid", bus.sample_valid_o, 0);
    chk("rwait_data", bus.sample_data_o, 0);
    chk("rwait_channel", bus.sample_channel_o, 0);
    chk("rwait_busy", bus.busy_o, 0);
    chk("rwait_overrun", bus.overrun_o, 0);
    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sample_scheduler.md
SAMPLE_SCHEDULER -- requirements
Module: sample_scheduler

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 16, sample and counter width.
REQ-002 SHALL have parameter SYSTEM_FREQUENCY, default 100000000, clock rate in Hz.
REQ-003 SHALL have parameter SAMPLING_FREQUENCY, default 1000000, frame rate in Hz; DIV = SYSTEM_FREQUENCY/SAMPLING_FREQUENCY, DIV >= 2, DIV <= 2^WORD_LENGTH.
REQ-004 SHALL have parameter CHANNELS, default 4, number of converter channels; CH_W = max(1, $clog2(CHANNELS)).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, conversion watchdog limit (used only under REQ-027).
REQ-006 SHALL have ports: clock_i in 1 system clock; reset_i in 1 synchronous active-high reset.
REQ-007 SHALL have ports: enable_i in 1 run enable; channel_mask_i in CHANNELS channels to sample.
REQ-008 SHALL have ports: conv_start_o out 1 one-cycle start pulse; conv_channel_o out CH_W channel select; conv_done_i in 1 conversion complete; conv_data_i in WORD_LENGTH result.
REQ-009 SHALL have ports: sample_valid_o out 1; sample_ready_i in 1; sample_data_o out WORD_LENGTH; sample_channel_o out CH_W.
REQ-010 SHALL have ports: busy_o out 1 frame in progress; overrun_o out 1 sticky missed-frame flag.

Function
REQ-011 Prescaler SHALL count 0..DIV-1 while enable_i=1, wrap to 0, and assert internal tick in the cycle count = DIV-1; count held at 0 while enable_i=0.
REQ-012 FSM states SHALL be IDLE, START, WAIT, OUTPUT; busy_o=1 in all states except IDLE.
REQ-013 IDLE: on tick with channel_mask_i != 0, latch mask, select lowest set channel, go START; tick with mask 0 SHALL be ignored (no frame, no overrun).
REQ-014 START: conv_start_o=1 for exactly this cycle, go WAIT; tick at cycle T SHALL give conv_start_o at T+1.
REQ-015 conv_channel_o SHALL hold the selected channel from START through OUTPUT.
REQ-016 WAIT: on conv_done_i=1 capture conv_data_i and channel, go OUTPUT; sample_valid_o SHALL rise the cycle after conv_done_i.
REQ-017 OUTPUT: sample_valid_o, sample_data_o, sample_channel_o SHALL be held stable until sample_valid_o & sample_ready_i.
REQ-018 On handshake SHALL advance to next higher set bit of latched mask and go START (conv_start_o the next cycle), or go IDLE when none remain.
REQ-019 Changes on channel_mask_i during a frame SHALL be ignored until the next frame.
REQ-020 Tick in any state other than IDLE SHALL be dropped and set overrun_o; overrun_o clears only on reset or enable_i=0.
REQ-021 Simultaneous conv_done_i and tick in WAIT SHALL both capture data and set overrun_o.
REQ-022 enable_i=0 in any state SHALL abort to IDLE next cycle with sample_valid_o=0; conv_done_i in IDLE SHALL be ignored.

Reset
REQ-023 reset_i=1 at a clock edge SHALL force IDLE, prescaler 0, latched mask 0, regardless of state.
REQ-024 Reset values: conv_start_o=0, conv_channel_o=0, sample_valid_o=0, sample_data_o=0, sample_channel_o=0, busy_o=0, overrun_o=0.
REQ-025 reset_i SHALL take priority over enable_i, tick, conv_done_i and handshake.

Configuration
REQ-026 Macro SAMPLE_SCHEDULER_TIMEOUT_EN SHALL select the conversion watchdog.
REQ-027 Defined: add port timeout_o out 1 (reset 0, sticky, cleared like overrun_o); WAIT lasting TIMEOUT_CYCLES cycles without conv_done_i SHALL set timeout_o, skip that channel (no sample output) and advance as in REQ-018.
REQ-028 Undefined: no timeout_o port, no watchdog counter; WAIT holds indefinitely until conv_done_i or enable_i=0.

Verification
REQ-029 Defaults, mask=4'b0101, enable held, done 3 cycles after each start, ready=1 -> starts on ch0 then ch2, samples tagged 0 and 2, new frame every 100 cycles, overrun_o=0.
REQ-030 mask=4'b1111, ready held 0 for 50 cycles on ch0 sample -> data stable 50 cycles, no further conv_start_o, ch1 start one cycle after ready rises.
REQ-031 Frame stalled past cycle 100 (ready=0) -> second tick dropped, overrun_o=1 until enable_i=0.
REQ-032 Reset pulsed during WAIT with conv_done_i asserted same cycle -> all outputs at reset values next cycle, no sample emitted.
REQ-033 mask=0 for 300 cycles -> no conv_start_o, busy_o=0, overrun_o=0.
REQ-034 With SAMPLE_SCHEDULER_TIMEOUT_EN, TIMEOUT_CYCLES=16, conv_done_i never on ch1, mask=4'b0011 -> ch0 sample, timeout_o=1 after 16 WAIT cycles, frame ends in IDLE.
